// File: rtl/game_timer_pkg.sv
// Shared definitions for the game timer and the game-state FSM.
// Provides the timer state encoding, default timing constants and BCD helpers.
package game_timer_pkg;

    typedef enum logic [1:0] {
        TIMER_IDLE     = 2'd0,
        TIMER_COUNTING = 2'd1,
        TIMER_HOLD     = 2'd2
    } timer_state_t;

    localparam int unsigned DEFAULT_CLOCK_HZ     = 50_000_000;
    localparam int unsigned DEFAULT_GAME_SECONDS = 60;

    function automatic logic [3:0] bcd_tens(input int unsigned value);
        return 4'(value / 10);
    endfunction

    function automatic logic [3:0] bcd_ones(input int unsigned value);
        return 4'(value % 10);
    endfunction

endpackage

// File: rtl/game_timer_tick_prescaler.sv
// Divides Clock down to a one-cycle Tick every CLOCK_HZ enabled cycles.
// Clear holds the count at zero; Enable low freezes the residual count.
module tick_prescaler #(
    parameter int unsigned CLOCK_HZ = game_timer_pkg::DEFAULT_CLOCK_HZ
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Tick
);

    localparam int unsigned W = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
    localparam logic [W-1:0] TERMINAL = W'(CLOCK_HZ - 1);

    logic [W-1:0] count_q;

    // Decoded from the count so the wrap edge and the tick coincide; the top registers it.
    assign Tick = Enable && !Clear && (count_q == TERMINAL);

    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            count_q <= '0;
        end else if (Enable) begin
            count_q <= (count_q == TERMINAL) ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/game_timer.sv
// Whole-second countdown for the game-state FSM, with a one-cycle expiry pulse
// and binary plus BCD seconds-remaining outputs for the display.
module game_timer #(
    parameter int unsigned CLOCK_HZ     = game_timer_pkg::DEFAULT_CLOCK_HZ,
    parameter int unsigned GAME_SECONDS = game_timer_pkg::DEFAULT_GAME_SECONDS,
    parameter int unsigned SEC_WIDTH    = 7
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Running,
    input  logic                 Pause,
    output logic                 TimerDone,
    output logic                 SecTick,
    output logic [SEC_WIDTH-1:0] SecondsLeft,
    output logic [3:0]           SecondsTens,
    output logic [3:0]           SecondsOnes
);

    import game_timer_pkg::*;

    localparam logic [SEC_WIDTH-1:0] RELOAD_SECS = SEC_WIDTH'(GAME_SECONDS);
    localparam logic [3:0]           RELOAD_TENS = bcd_tens(GAME_SECONDS);
    localparam logic [3:0]           RELOAD_ONES = bcd_ones(GAME_SECONDS);

    timer_state_t         state_q, state_d;
    logic [SEC_WIDTH-1:0] secs_d;
    logic [3:0]           tens_d, ones_d;
    logic                 done_d, sec_tick_d;
    logic                 tick;

    tick_prescaler #(.CLOCK_HZ(CLOCK_HZ)) u_prescaler (
        .Clock  (Clock),
        .Reset  (Reset),
        .Clear  ((state_q != TIMER_COUNTING) || !Running),
        .Enable (!Pause),
        .Tick   (tick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= TIMER_IDLE;
            TimerDone   <= 1'b0;
            SecTick     <= 1'b0;
            SecondsLeft <= RELOAD_SECS;
            SecondsTens <= RELOAD_TENS;
            SecondsOnes <= RELOAD_ONES;
        end else begin
            state_q     <= state_d;
            TimerDone   <= done_d;
            SecTick     <= sec_tick_d;
            SecondsLeft <= secs_d;
            SecondsTens <= tens_d;
            SecondsOnes <= ones_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        secs_d     = SecondsLeft;
        tens_d     = SecondsTens;
        ones_d     = SecondsOnes;
        done_d     = 1'b0;
        sec_tick_d = 1'b0;

        unique case (state_q)
            TIMER_IDLE: begin
                secs_d = RELOAD_SECS;
                tens_d = RELOAD_TENS;
                ones_d = RELOAD_ONES;
                if (Running) state_d = TIMER_COUNTING;
            end
            TIMER_COUNTING: begin
                // Abort takes priority over a coincident tick, expiry or pause.
                if (!Running) begin
                    state_d = TIMER_IDLE;
                    secs_d  = RELOAD_SECS;
                    tens_d  = RELOAD_TENS;
                    ones_d  = RELOAD_ONES;
                end else if (tick && (SecondsLeft != '0)) begin
                    sec_tick_d = 1'b1;
                    secs_d     = SecondsLeft - SEC_WIDTH'(1);
                    if (SecondsOnes == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = SecondsTens - 4'd1;
                    end else begin
                        ones_d = SecondsOnes - 4'd1;
                    end
                    if (SecondsLeft == SEC_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = TIMER_HOLD;
                    end
                end
            end
            TIMER_HOLD: begin
                secs_d = '0;
                tens_d = '0;
                ones_d = '0;
                if (!Running) begin
                    state_d = TIMER_IDLE;
                    secs_d  = RELOAD_SECS;
                    tens_d  = RELOAD_TENS;
                    ones_d  = RELOAD_ONES;
                end
            end
            default: begin
                state_d = TIMER_IDLE;
            end
        endcase
    end

endmodule
